partial_products: RTL and testbench
===================================

Name: partial_products

Overview:
- Partial-product generator for the 8x8 unsigned multiplier datapath in the 2x2 matrix multiplier.
- Produces one row per multiplier bit: row i equals B when A[i]=1, else zero. In other words, P[i] = B AND {WIDTH{A[i]}}.
- Feeds the downstream adder/compressor tree.
- Registered by default (1-cycle latency); a compile-time option makes it purely combinational.

Parameters:
- WIDTH, 8, operand width. It is also the number of partial-product rows and the width of each row.

Ports:
- clk  input  1  system clock, rising-edge active.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  A and B are valid this cycle.
- A  input  WIDTH  multiplier operand; bit i selects row i.
- B  input  WIDTH  multiplicand operand.
- P  output  WIDTH x WIDTH  unpacked array P[WIDTH-1:0], each element WIDTH bits wide; P[i] is the row for A[i].
- out_valid  output  1  P holds a valid result.
- row_nz  output  WIDTH  row_nz[i] = 1 when P[i] != 0, which is A[i] AND (B != 0).

Behaviour:
- Arithmetic:
  - For every row i in 0..WIDTH-1 and every bit j: P[i][j] = A[i] & B[j].
  - Rows are not shifted. Weighting by 2^i is done by the consumer.
  - Unsigned only. There is no sign extension and no carry.
- Reset (rst=1, asynchronous):
  - Every P[i] = 0, out_valid = 0, row_nz = 0, immediately and regardless of clk.
  - On deassertion, outputs stay 0 until the first accepted input.
- Registered mode (default):
  - On a rising clk edge with in_valid=1, compute P and row_nz from the current A and B and register them; set out_valid=1.
  - Latency is exactly 1 cycle.
  - On a rising clk edge with in_valid=0, P and row_nz hold their last values and out_valid=0.
- Back-to-back inputs:
  - One result per cycle, with no stall and no backpressure.
  - Each cycle's P corresponds to the inputs of the immediately preceding accepted cycle.
- Reset mid-operation: any in-flight result is discarded and outputs go to 0.
- Reset versus clock: if rst is asserted on the same edge as in_valid, reset wins.
- Boundary values:
  - A=0 or B=0 gives all rows 0 and row_nz=0.
  - A all ones gives every row equal to B.
  - B all ones gives P[i] all ones wherever A[i]=1.
- No X propagation requirement beyond standard RTL semantics. Outputs must never be X after reset.

Optional Feature:
- Macro: PP_COMB_BYPASS_EN.
- When defined:
  - The output register is removed.
  - P and row_nz are purely combinational functions of A and B, valid within the same delta/settle time.
  - out_valid = in_valid combinationally.
  - clk and rst remain ports but do not affect P, row_nz or out_valid.
- When undefined: the registered 1-cycle behaviour above applies.

Test Plan:
- Zero operands: A=8'h00, B=8'h00 -> all eight P[i]=8'h00, row_nz=8'h00.
- Unit: A=8'h01, B=8'h01 -> P[0]=8'h01, P[1..7]=8'h00, row_nz=8'h01.
- All multiplier bits set: A=8'hFF, B=8'h01 -> P[0..7]=8'h01 each, row_nz=8'hFF.
- Single multiplier bit, full multiplicand: A=8'h01, B=8'hFF -> P[0]=8'hFF, P[1..7]=8'h00, row_nz=8'h01.
- Maximum: A=8'hFF, B=8'hFF -> P[0..7]=8'hFF each.
- Timing and control, registered mode:
  - Outputs update exactly 1 cycle after in_valid.
  - Outputs hold when in_valid=0, with out_valid=0.
  - Asserting rst mid-stream (after A=8'hFF, B=8'hFF) clears all P to 8'h00 asynchronously, before the next clk edge.
  - With PP_COMB_BYPASS_EN, all of the above values appear 1 ns after the inputs change, with no clock edges.

Source files
------------

// File: rtl/partial_products.sv
// partial_products: one unshifted partial-product row per multiplier bit, P[i] = B & {WIDTH{A[i]}}.
// Registered with 1-cycle latency by default; defining PP_COMB_BYPASS_EN makes it purely combinational.
module partial_products #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] P [WIDTH-1:0],
    output logic             out_valid,
    output logic [WIDTH-1:0] row_nz
);

    logic [WIDTH-1:0] pp_s [WIDTH-1:0];
    logic [WIDTH-1:0] nz_s;

    function automatic logic [WIDTH-1:0] pp_row(input logic sel, input logic [WIDTH-1:0] mcand);
        return mcand & {WIDTH{sel}};
    endfunction

    // Row generation; a row is nonzero only when its select bit is set and B is nonzero
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            pp_s[i] = pp_row(A[i], B);
            nz_s[i] = |pp_s[i];
        end
    end

`ifdef PP_COMB_BYPASS_EN
    // clk and rst stay on the port list for drop-in compatibility but have no effect here
    logic unused_clk_rst_s;
    assign unused_clk_rst_s = clk ^ rst;

    // Outputs follow the inputs directly
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            P[i] = pp_s[i];
        end
        row_nz    = nz_s;
        out_valid = in_valid;
    end
`else
    logic [WIDTH-1:0] p_r [WIDTH-1:0];
    logic [WIDTH-1:0] nz_r;
    logic             valid_r;

    // Output register: capture on in_valid, otherwise hold rows and drop valid
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < WIDTH; i++) begin
                p_r[i] <= {WIDTH{1'b0}};
            end
            nz_r    <= {WIDTH{1'b0}};
            valid_r <= 1'b0;
        end else if (in_valid) begin
            for (int i = 0; i < WIDTH; i++) begin
                p_r[i] <= pp_s[i];
            end
            nz_r    <= nz_s;
            valid_r <= 1'b1;
        end else begin
            valid_r <= 1'b0;
        end
    end

    // Drive ports from the register
    always_comb begin
        for (int i = 0; i < WIDTH; i++) begin
            P[i] = p_r[i];
        end
        row_nz    = nz_r;
        out_valid = valid_r;
    end
`endif

endmodule

// File: tb/tb_partial_products.sv
// Scoreboard bench for partial_products: stimulus pushes hand-computed rows, a negedge monitor pops and compares.
// Also covers the PP_COMB_BYPASS_EN build when compiled with that macro.
module tb_partial_products;

    typedef struct packed {
        logic [63:0] p;
        logic [7:0]  nz;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic [7:0] A = 8'h00;
    logic [7:0] B = 8'h00;
    logic [7:0] P [7:0];
    logic       out_valid;
    logic [7:0] row_nz;

    int   tests = 0;
    int   fails = 0;
    exp_t sb_q[$];
    exp_t last_exp = '{p: 64'h0, nz: 8'h00};

    partial_products #(.WIDTH(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .A(A), .B(B),
        .P(P), .out_valid(out_valid), .row_nz(row_nz)
    );

    always #5 clk = ~clk;

    function automatic logic [63:0] flat_p();
        logic [63:0] f;
        for (int i = 0; i < 8; i++) f[i*8 +: 8] = P[i];
        return f;
    endfunction

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
        end
    endtask

    task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [63:0] p, input logic [7:0] nz);
        @(posedge clk); #1;
        A = a; B = b; in_valid = 1'b1;
        sb_q.push_back('{p: p, nz: nz});
    endtask

    task automatic idle(input int n);
        for (int k = 0; k < n; k++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    // Monitor: pop on out_valid, otherwise the rows must still hold the last result
    always @(negedge clk) begin
        exp_t e;
`ifdef PP_COMB_BYPASS_EN
        if (1'b1) begin
`else
        if (!rst) begin
`endif
            if (out_valid === 1'b1) begin
                if (sb_q.size() == 0) begin
                    check64("unexpected_out_valid", 64'd1, 64'd0);
                end else begin
                    e = sb_q.pop_front();
                    check64("P_rows", flat_p(), e.p);
                    check64("row_nz", {56'h0, row_nz}, {56'h0, e.nz});
                    last_exp = e;
                end
            end else begin
                check64("hold_P", flat_p(), last_exp.p);
                check64("hold_row_nz", {56'h0, row_nz}, {56'h0, last_exp.nz});
            end
        end
    end

    initial begin
        #1;
        check64("reset_P", flat_p(), 64'h0);
        check64("reset_out_valid", {63'h0, out_valid}, 64'h0);
        check64("reset_row_nz", {56'h0, row_nz}, 64'h0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        idle(2);

        // Back-to-back directed vectors: P[7]..P[0] as bytes, MSB first
        drive(8'h00, 8'h00, 64'h0000000000000000, 8'h00);
        drive(8'h01, 8'h01, 64'h0000000000000001, 8'h01);
        drive(8'hFF, 8'h01, 64'h0101010101010101, 8'hFF);
        drive(8'h01, 8'hFF, 64'h00000000000000FF, 8'h01);
        drive(8'hFF, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        drive(8'hA5, 8'h3C, 64'h3C003C00003C003C, 8'hA5);
        drive(8'h80, 8'h00, 64'h0000000000000000, 8'h00);
        drive(8'h00, 8'h7E, 64'h0000000000000000, 8'h00);
        idle(3);

        // Isolated transaction between gaps: result must appear exactly one cycle later
        drive(8'h5A, 8'h81, 64'h0081008181008100, 8'h5A);
        idle(3);

        drive(8'hFF, 8'hFF, 64'hFFFFFFFFFFFFFFFF, 8'hFF);
        idle(1);
        @(negedge clk); #1;
`ifdef PP_COMB_BYPASS_EN
        rst = 1'b1;
        #1;
        check64("bypass_rst_P", flat_p(), 64'hFFFFFFFFFFFFFFFF);
        check64("bypass_rst_out_valid", {63'h0, out_valid}, 64'h0);
        drive(8'h3C, 8'h0F, 64'h00000F0F0F0F0000, 8'h3C);
        idle(1);
        rst = 1'b0;
        idle(2);
`else
        rst = 1'b1;
        #1;
        check64("async_rst_P", flat_p(), 64'h0);
        check64("async_rst_out_valid", {63'h0, out_valid}, 64'h0);
        check64("async_rst_row_nz", {56'h0, row_nz}, 64'h0);
        last_exp = '{p: 64'h0, nz: 8'h00};
        // Reset asserted on the same edge as in_valid: reset wins
        A = 8'hFF; B = 8'hFF; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        rst = 1'b0;
        check64("rst_wins_P", flat_p(), 64'h0);
        check64("rst_wins_out_valid", {63'h0, out_valid}, 64'h0);
        idle(2);
        drive(8'h3C, 8'h0F, 64'h00000F0F0F0F0000, 8'h3C);
        idle(2);
`endif
        check64("scoreboard_drained", {32'h0, sb_q.size()}, 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
